// File: rtl/mac_sa_param.sv
// Sequential shift-add multiply-accumulate with a valid/ready operand handshake.
// Each product takes WIDTH multiply cycles plus one accumulate cycle, followed by a one-cycle strobe.
module mac_sa_param #(
  parameter int WIDTH = 256,
  parameter int GUARD = 8,
  localparam int ACC_W = 2 * WIDTH + GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             busy,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt;
  logic               clr_q;
  logic [ACC_W:0]     sum;
  logic               accept;

  // Sum is one bit wider than the accumulator so the carry out becomes the overflow flag.
  function automatic logic [ACC_W:0] acc_sum(input logic             clr,
                                             input logic [ACC_W-1:0] acc,
                                             input logic [2*WIDTH-1:0] p);
    logic [ACC_W:0] base;
    base = clr ? '0 : {1'b0, acc};
    return base + {{(GUARD + 1){1'b0}}, p};
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign sum      = acc_sum(clr_q, acc_out, prod);

  // Control: state, accumulator and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) state <= MULT;
        MULT: if (cnt == CNT_LAST) state <= ACC;
        ACC: begin
          acc_out   <= sum[ACC_W-1:0];
          out_valid <= 1'b1;
          if (sum[ACC_W])
            ovf <= 1'b1;
          else if (clr_q)
            ovf <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture and one multiplier bit per MULT cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh  <= {{WIDTH{1'b0}}, a};
      b_sh  <= b;
      clr_q <= in_clr;
      prod  <= '0;
      cnt   <= '0;
    end else if (state == MULT) begin
      if (b_sh[0])
        prod <= prod + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_sa_param.sv
// Directed plus randomized bench for mac_sa_param (WIDTH=8, GUARD=8) against an arithmetic MAC model.
module tb_mac_sa_param;
  localparam int WIDTH = 8;
  localparam int GUARD = 8;
  localparam int ACC_W = 2 * WIDTH + GUARD;
  localparam longint MODV = longint'(1) << ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_clr = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             busy;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  longint m_acc = 0;
  bit     m_ovf = 0;

  mac_sa_param #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_clr(in_clr), .acc_out(acc_out),
    .out_valid(out_valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: one MAC step on plain integers.
  task automatic model_op(input int unsigned ma, input int unsigned mb, input bit mclr);
    longint s;
    s = (mclr ? 0 : m_acc) + longint'(ma) * longint'(mb);
    if (s >= MODV) m_ovf = 1;
    else if (mclr) m_ovf = 0;
    m_acc = s % MODV;
  endtask

  // Full operation: offer operands, expect the strobe exactly WIDTH+1 edges after accept.
  task automatic do_op(input int unsigned oa, input int unsigned ob, input bit oclr,
                       input bit detail);
    int n;
    @(negedge clk);
    chk("ready_before", 64'(in_ready), 64'd1);
    a = WIDTH'(oa); b = WIDTH'(ob); in_clr = oclr; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_op(oa, ob, oclr);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      if (out_valid) break;
      if (detail) begin
        chk("ready_low", 64'(in_ready), 64'd0);
        chk("busy_high", 64'(busy), 64'd1);
      end
      n++;
    end
    chk("latency", 64'(n), 64'(WIDTH + 1));
    chk("acc_out", 64'(acc_out), 64'(m_acc));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (detail) begin
      chk("busy_at_strobe", 64'(busy), 64'd0);
      @(negedge clk);
      chk("strobe_one_cycle", 64'(out_valid), 64'd0);
      chk("acc_hold", 64'(acc_out), 64'(m_acc));
    end
  endtask

  initial begin
    int unsigned qa[$];
    int unsigned qb[$];
    bit          qc[$];
    int          acc_cyc[$];
    int          cyc;
    int          results;
    int          seen;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_acc", 64'(acc_out), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Basic and accumulate
    do_op(3, 5, 1, 1);
    do_op(255, 255, 1, 1);
    do_op(255, 255, 0, 1);
    chk("accum_value", 64'(acc_out), 64'd130050);

    // Overflow: 259 ops of 255*255 total
    do_op(255, 255, 1, 0);
    for (int i = 1; i < 258; i++) do_op(255, 255, 0, 0);
    chk("op258_acc", 64'(acc_out), 64'd16776450);
    chk("op258_ovf", 64'(ovf), 64'd0);
    do_op(255, 255, 0, 0);
    chk("op259_acc", 64'(acc_out), 64'd64259);
    chk("op259_ovf", 64'(ovf), 64'd1);
    do_op(1, 1, 1, 1);
    chk("clr_ovf", 64'(ovf), 64'd0);

    // Random single ops
    for (int i = 0; i < 20; i++)
      do_op($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 0);

    // Back-pressure: in_valid held high, operands change every cycle
    cyc = 0; results = 0; seen = 0;
    in_valid = 1'b1;
    while (results < 3 && cyc < 80) begin
      @(negedge clk);
      if (out_valid) begin
        model_op(qa.pop_front(), qb.pop_front(), qc.pop_front());
        chk("bp_acc", 64'(acc_out), 64'(m_acc));
        chk("bp_ovf", 64'(ovf), 64'(m_ovf));
        results++;
      end
      a = WIDTH'($urandom); b = WIDTH'($urandom); in_clr = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        qa.push_back(int'(a)); qb.push_back(int'(b)); qc.push_back(in_clr);
        acc_cyc.push_back(cyc);
        seen++;
      end else if (seen >= 3) begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_results", 64'(results), 64'd3);
    chk("bp_accepts", 64'(acc_cyc.size()), 64'd3);
    if (acc_cyc.size() == 3) begin
      chk("ii_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(WIDTH + 2));
      chk("ii_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(WIDTH + 2));
    end

    // Zero operand keeps the accumulator
    do_op(3, 5, 1, 0);
    do_op(0, 200, 0, 1);
    chk("zero_op_acc", 64'(acc_out), 64'd15);

    // Reset mid-operation on the 4th MULT edge
    @(negedge clk);
    a = 8'd7; b = 8'd9; in_clr = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_ovf = 0;
    chk("midrst_acc", 64'(acc_out), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_strobe", 64'(seen), 64'd0);
    do_op(6, 7, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_sa_param.md
# mac_sa_param

Parametrised sequential multiply-accumulate unit. It multiplies two unsigned WIDTH-bit operands with an iterative shift-add datapath, one multiplier bit per cycle, and adds each product into a wide accumulator with guard bits. Compared with the fixed 256-bit MAC it adds a valid/ready operand handshake, a per-operation accumulator-clear mode, a result strobe and a sticky overflow flag. It sits between an operand source (such as a FIFO or a host sequencer) and any consumer of the running sum.

## Interface
- WIDTH, 256, operand width in bits (≥2)
- GUARD, 8, accumulator guard bits; ACC_W = 2*WIDTH + GUARD
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  unit can accept an operand pair
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- in_clr  in  1  sampled with a/b; 1 means this product replaces the accumulator instead of adding to it
- acc_out  out  ACC_W  accumulator value
- out_valid  out  1  one-cycle strobe: acc_out was just updated
- busy  out  1  operation in progress (state ≠ IDLE)
- ovf  out  1  sticky accumulator overflow

## Operation
- FSM states: IDLE → MULT → ACC → IDLE.
- in_ready = (state == IDLE). An operation is accepted on an edge where in_valid && in_ready.
- On accept:
  - latch a_sh = zero-extended a (2*WIDTH bits), b_sh = b, clr_q = in_clr;
  - product = 0, cnt = 0;
  - go to MULT.
- MULT, one iteration per cycle:
  - if b_sh[0], product += a_sh (2*WIDTH-bit add, never carries out);
  - a_sh <<= 1, b_sh >>= 1, cnt++;
  - after the iteration with cnt == WIDTH-1, go to ACC.
  - Exactly WIDTH iterations are always run: no early exit, even for zero operands.
- ACC, single cycle:
  - sum = (clr_q ? 0 : acc) + zero-extended product, computed ACC_W+1 bits wide;
  - acc ← sum[ACC_W-1:0], so the accumulator wraps modulo 2^ACC_W;
  - out_valid = 1 for the following cycle; go to IDLE.
- ovf:
  - set when sum[ACC_W] = 1;
  - cleared in ACC when clr_q = 1 and there is no carry;
  - otherwise holds its value.
- a, b and in_clr are ignored whenever in_ready = 0. Operands are captured only at accept.
- Reset values: state IDLE, acc_out 0, out_valid 0, ovf 0, busy 0, in_ready 1 in the first cycle after reset deasserts. Internal product, a_sh, b_sh and cnt are don't-care.
- Reset mid-operation: on the edge where rst = 1, everything returns to reset values. The in-flight operation is discarded and produces no out_valid pulse.
- rst has priority over in_valid on the same edge.

## Timing
- Edges are counted from the accept edge, E0:
  - E1…E_WIDTH: the multiply iterations;
  - E_WIDTH: state becomes ACC;
  - E_WIDTH+1: acc_out updated, out_valid high for one cycle, in_ready back to 1.
- Latency: WIDTH+1 edges from accept to the updated acc_out.
- The earliest next accept is E_WIDTH+2, so the initiation interval is WIDTH+2 cycles.
- out_valid is never high for two consecutive cycles.
- busy is high from after E0 through the cycle before E_WIDTH+1 completes, and low when out_valid is high.
- All outputs are registered. Apart from the single-cycle strobe, acc_out and ovf hold their values between strobes.

## Test plan
All scenarios use WIDTH=8, GUARD=8, ACC_W=24.
- Basic: reset, then accept a=3, b=5, in_clr=1 → 9 edges after accept, acc_out=15 and out_valid is a one-cycle pulse, ovf=0; in_ready=0 for 9 cycles after accept.
- Accumulate: a=255, b=255, clr=1, then the same operands with clr=0 → acc_out=65025, then 130050. Back-to-back in_valid gives accepts exactly 10 cycles apart.
- Overflow: accept 255×255 with clr=1, then 258 further times with clr=0 (259 ops total) → after op 258, acc_out=16776450 and ovf=0; after op 259, acc_out=64259 and ovf=1. The next op with clr=1 and a=1, b=1 gives acc_out=1 and ovf=0.
- Back-pressure: hold in_valid=1 and change a/b every cycle during MULT → only the accept-edge values are used, and no second accept occurs before in_ready returns.
- Reset mid-op: accept a=7, b=9, then assert rst on the 4th edge of MULT → acc_out=0, ovf=0, no out_valid pulse, in_ready=1 in the next cycle.
- Zero operand: with acc=15, accept a=0, b=200, clr=0 → acc_out stays 15 and out_valid still pulses at the standard 9-edge latency.
